// File: rtl/mips_alu_pkg.sv
// Shared opcodes, FSM state type and compare helper for the iterative MIPS ALU.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_MULT  = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_DIV   = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MFHI  = 4'b1101;
    localparam logic [3:0] ALU_MFLO  = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    // Signed a<b: differing signs decide directly, otherwise the difference sign is exact.
    function automatic logic slt_signed(input logic a_msb, input logic b_msb,
                                        input logic diff_msb);
        return (a_msb != b_msb) ? a_msb : diff_msb;
    endfunction

endpackage

// File: rtl/mips_muldiv_core.sv
// Unsigned shift-add multiply / restoring divide step engine; divider present only with ALU_DIV_EN.
module mips_muldiv_core
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
`ifdef ALU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic             last,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   div_shift, div_diff;
`endif

    // {hi,lo} is the product register for multiply and {remainder,quotient} for divide.
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        mul_add = lo_q[0] ? opb_q : '0;
        mul_sum = {1'b0, hi_q} + {1'b0, mul_add};
`ifdef ALU_DIV_EN
        div_d     = div_q;
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
`endif
        if (load) begin
            hi_d  = '0;
            lo_d  = mag_a;
            opb_d = mag_b;
            cnt_d = '0;
`ifdef ALU_DIV_EN
            div_d = is_div;
`endif
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
`ifdef ALU_DIV_EN
            if (div_q) begin
                if (!div_diff[WIDTH]) begin
                    hi_d = div_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opb_q <= '0;
            cnt_q <= '0;
`ifdef ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
`ifdef ALU_DIV_EN
            div_q <= div_d;
`endif
        end
    end

    assign last   = cnt_q == CW'(WIDTH - 1);
    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

endmodule

// File: rtl/mips_alu_iter.sv
// Registered MIPS ALU with iterative mul/div, HI/LO and start/busy/done; ALU_DIV_EN enables DIV/DIVU.
// Handshake: start is taken on a rising edge only while busy=0; done pulses one cycle when outputs update.
module mips_alu_iter
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div0,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);
    localparam int M = WIDTH - 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic               ovf_q, ovf_d, div0_q, div0_d, ill_q, ill_d, done_q, done_d;
    logic               negp_q, negp_d;
`ifdef ALU_DIV_EN
    logic               isdiv_q, isdiv_d, negr_q, negr_d, bz_q, bz_d;
    logic [WIDTH-1:0]   a_q, a_d;
`endif
    logic               sgn, core_load, core_step, core_last;
    logic [WIDTH-1:0]   mag_a, mag_b, sum, diff, core_hi, core_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;

    mips_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (core_load),
        .step   (core_step),
`ifdef ALU_DIV_EN
        .is_div (alu_control == ALU_DIVU || alu_control == ALU_DIV),
`endif
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .last   (core_last),
        .acc_hi (core_hi),
        .acc_lo (core_lo)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        ovf_d     = ovf_q;
        div0_d    = div0_q;
        ill_d     = ill_q;
        negp_d    = negp_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
`ifdef ALU_DIV_EN
        isdiv_d = isdiv_q;
        negr_d  = negr_q;
        bz_d    = bz_q;
        a_d     = a_q;
`endif
        sum   = a + b;
        diff  = a - b;
        sgn   = (alu_control == ALU_MULT) || (alu_control == ALU_DIV);
        mag_a = (sgn && a[M]) ? -a : a;
        mag_b = (sgn && b[M]) ? -b : b;
        prod  = {core_hi, core_lo};
        if (negp_q) prod = -prod;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (isdiv_q) begin
            if (bz_q) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                fix_lo = negp_q ? -core_lo : core_lo;
                fix_hi = negr_q ? -core_hi : core_hi;
            end
        end
`endif
        case (state_q)
            IDLE: if (start) begin
                done_d = 1'b1;
                ovf_d  = 1'b0;
                ill_d  = 1'b0;
                div0_d = 1'b0;
                case (alu_control)
                    ALU_AND:  result_d = a & b;
                    ALU_OR:   result_d = a | b;
                    ALU_NOR:  result_d = ~(a | b);
                    ALU_ADD: begin
                        result_d = sum;
                        ovf_d    = (a[M] == b[M]) && (sum[M] != a[M]);
                    end
                    ALU_SUB: begin
                        result_d = diff;
                        ovf_d    = (a[M] != b[M]) && (diff[M] != a[M]);
                    end
                    ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_signed(a[M], b[M], diff[M])};
                    ALU_MFHI: result_d = hi_q;
                    ALU_MFLO: result_d = lo_q;
                    ALU_MULTU, ALU_MULT: begin
                        done_d    = 1'b0;
                        div0_d    = div0_q;
                        ovf_d     = ovf_q;
                        ill_d     = ill_q;
                        state_d   = RUN;
                        core_load = 1'b1;
                        negp_d    = sgn && (a[M] ^ b[M]);
`ifdef ALU_DIV_EN
                        isdiv_d   = 1'b0;
`endif
                    end
`ifdef ALU_DIV_EN
                    ALU_DIVU, ALU_DIV: begin
                        done_d    = 1'b0;
                        div0_d    = div0_q;
                        ovf_d     = ovf_q;
                        ill_d     = ill_q;
                        state_d   = RUN;
                        core_load = 1'b1;
                        negp_d    = sgn && (a[M] ^ b[M]);
                        isdiv_d   = 1'b1;
                        negr_d    = sgn && a[M];
                        bz_d      = (b == '0);
                        a_d       = a;
                    end
`endif
                    default: begin
                        result_d = '0;
                        ill_d    = 1'b1;
                    end
                endcase
            end
            RUN: begin
                core_step = 1'b1;
                if (core_last) state_d = FIX;
            end
            FIX: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                hi_d     = fix_hi;
                lo_d     = fix_lo;
                result_d = fix_lo;
                ovf_d    = 1'b0;
                ill_d    = 1'b0;
`ifdef ALU_DIV_EN
                div0_d   = isdiv_q && bz_q;
`else
                div0_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b0;
            negp_q   <= 1'b0;
`ifdef ALU_DIV_EN
            isdiv_q  <= 1'b0;
            negr_q   <= 1'b0;
            bz_q     <= 1'b0;
            a_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            ovf_q    <= ovf_d;
            div0_q   <= div0_d;
            ill_q    <= ill_d;
            done_q   <= done_d;
            negp_q   <= negp_d;
`ifdef ALU_DIV_EN
            isdiv_q  <= isdiv_d;
            negr_q   <= negr_d;
            bz_q     <= bz_d;
            a_q      <= a_d;
`endif
        end
    end

    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = result_q == '0;
    assign overflow  = ovf_q;
    assign div0      = div0_q;
    assign illegal   = ill_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_alu_iter.sv
// Directed table plus multi-cycle sequences for mips_alu_iter (WIDTH=32).
module tb_mips_alu_iter;
    import mips_alu_pkg::*;

    logic        clk, rst_n, start;
    logic [3:0]  alu_control;
    logic [31:0] a, b, result, hi, lo;
    logic        busy, done, zero, overflow, div0, illegal;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    mips_alu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero),
        .overflow(overflow), .div0(div0), .illegal(illegal), .hi(hi), .lo(lo),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        il;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the accepting edge.
    task automatic alu_op(input logic [3:0] ctrl, input logic [31:0] va, input logic [31:0] vb);
        alu_control = ctrl;
        a           = va;
        b           = vb;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Launches a mul/div, pokes an ignored start at edge 10, returns at the negedge where done is seen.
    task automatic run_md(input logic [3:0] ctrl, input logic [31:0] va, input logic [31:0] vb,
                          output int busy_cnt, output int done_at);
        busy_cnt = 0;
        done_at  = -1;
        alu_op(ctrl, va, vb);
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                done_at = k;
                break;
            end
            if (busy) busy_cnt++;
            a = $urandom;
            b = $urandom;
            alu_control = ALU_AND;
            start = (k == 9);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    int bc, da, done_cnt;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        alu_control = 4'b0;
        a = '0;
        b = '0;
        vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'b0011,  32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{ALU_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{ALU_OR,   32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'b1111,  32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{ALU_MFHI, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'h1);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            alu_op(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_done", i), {31'b0, done}, 32'h1);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].z});
            chk($sformatf("v%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].ov});
            chk($sformatf("v%0d_illegal", i), {31'b0, illegal}, {31'b0, vecs[i].il});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'h0);
        end
        @(negedge clk);
        chk("done_pulse_drop", {31'b0, done}, 32'h0);

        run_md(ALU_MULT, 32'hFFFFFFFD, 32'h00000007, bc, da);
        chk("mult_busy_cycles", bc, 32'd33);
        chk("mult_done_at", da, 32'd33);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        chk("mult_result", result, 32'hFFFFFFEB);
        chk("mult_busy_at_done", {31'b0, busy}, 32'h0);
        @(negedge clk);
        chk("mult_done_pulse", {31'b0, done}, 32'h0);

        run_md(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, da);
        chk("multu_done_at", da, 32'd33);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        alu_op(ALU_MFHI, 32'h0, 32'h0);
        chk("mfhi_after_done", result, 32'hFFFFFFFE);
        alu_op(ALU_MFLO, 32'h0, 32'h0);
        chk("mflo_result", result, 32'h00000001);

`ifdef ALU_DIV_EN
        run_md(ALU_DIV, 32'hFFFFFFF9, 32'h00000002, bc, da);
        chk("div_done_at", da, 32'd33);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_div0", {31'b0, div0}, 32'h0);
        run_md(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, bc, da);
        chk("divmin_lo", lo, 32'h80000000);
        chk("divmin_hi", hi, 32'h00000000);
        chk("divmin_div0", {31'b0, div0}, 32'h0);
        run_md(ALU_DIVU, 32'h00000009, 32'h00000000, bc, da);
        chk("divu0_lo", lo, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 32'h00000009);
        chk("divu0_div0", {31'b0, div0}, 32'h1);
`else
        alu_op(ALU_DIV, 32'hFFFFFFF9, 32'h00000002);
        chk("nodiv_done", {31'b0, done}, 32'h1);
        chk("nodiv_illegal", {31'b0, illegal}, 32'h1);
        chk("nodiv_result", result, 32'h0);
        chk("nodiv_busy", {31'b0, busy}, 32'h0);
        chk("nodiv_hi", hi, 32'hFFFFFFFE);
        chk("nodiv_lo", lo, 32'h00000001);
        chk("nodiv_div0", {31'b0, div0}, 32'h0);
`endif

        alu_op(ALU_MULT, 32'h00000005, 32'h00000003);
        repeat (12) @(negedge clk);
        chk("mid_run_busy", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_zero", {31'b0, zero}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 32'd0);
        alu_op(ALU_AND, 32'h0000F0F0, 32'h0000FF00);
        chk("post_abort_and", result, 32'h0000F000);
        chk("post_abort_done", {31'b0, done}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_alu_iter.md
# mips_alu_iter

Parametrised, registered ALU for the MIPS datapath. It extends the bit-sliced single-cycle ALU with iterative multiply/divide, HI/LO registers and a start/busy/done handshake. Logic/arithmetic ops complete in one clock. MULT/MULTU/DIV/DIVU run over WIDTH+1 clocks while the pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result width (≥ 4)
- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `start` in 1, request; accepted only when `busy`=0
- `alu_control` in 4, opcode, sampled on the accepting edge
- `a`, `b` in WIDTH, operands, sampled on the accepting edge
- `busy` out 1, mul/div in progress
- `done` out 1, one-cycle pulse when outputs are valid
- `result` out WIDTH, registered result
- `zero` out 1, `result`==0
- `overflow` out 1, signed overflow (ADD/SUB only)
- `div0` out 1, last divide had `b`==0
- `illegal` out 1, last opcode undefined
- `hi`, `lo` out WIDTH, HI/LO architectural registers

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0/1), 1100 NOR
  - 1101 MFHI (result=`hi`), 1110 MFLO (result=`lo`)
  - 1000 MULTU, 1001 MULT, 1010 DIVU, 1011 DIV
  - Any other code: result=0, `illegal`=1.
- ADD/SUB wrap modulo 2^WIDTH. `overflow` = carry into MSB XOR carry out of MSB; it is 0 for all other ops.
- MULT/MULTU: {hi,lo} = 2·WIDTH-bit product, computed by shift-add on magnitudes with sign fixed in FIX.
- DIV/DIVU: lo=quotient, hi=remainder, computed by restoring division on magnitudes. Quotient truncates toward zero; remainder takes the sign of `a`.
- Divide by zero: lo=all ones, hi=`a`, `div0`=1.
- Signed most-negative/−1: lo=most-negative, hi=0, no flag.
- On a mul/div op, `result`=new `lo`. `zero`/`overflow` follow `result`.
- Flags (`div0`, `illegal`, `overflow`) are registered with `result`. They hold until the next `done`.
- FSM states:
  - IDLE: accept `start`. ALU op → stay IDLE and update outputs. Mul/div → RUN, load operand magnitudes, counter=0.
  - RUN: one iteration per clock. After WIDTH iterations → FIX.
  - FIX: apply signs, write hi/lo/result, pulse `done` → IDLE.

## Timing
- Reset (async, any state): FSM=IDLE; counter=0; `busy`, `done`, `zero`... all outputs 0, except `zero`=1 (result=0). `hi`, `lo`=0. An in-flight mul/div is discarded with no `done`.
- Accepting edge = edge 0.
- ALU/MF ops: outputs valid and `done`=1 for the cycle after edge 0 (latency 1). Back-to-back `start` each cycle is allowed.
- Mul/div timing:
  - `busy`=1 from edge 0 to edge WIDTH+1.
  - Outputs are written and `done`=1 during the cycle following edge WIDTH+1.
  - A new `start` can be accepted on edge WIDTH+2.
- `start` while `busy`=1 is ignored, with no queuing; `a`, `b`, `alu_control` may change freely during RUN.
- MFHI/MFLO accepted the cycle `done` is high for a mul/div return the new hi/lo.
- `hi`/`lo` change only in FIX or on reset.

## Configuration
- `ALU_DIV_EN` defined: divider datapath and DIV/DIVU are present as above.
- Not defined: no divider logic. 1010/1011 are treated as undefined: `illegal`=1, result=0, latency 1, hi/lo unchanged. `div0` is tied 0.

## Structure
- Package `mips_alu_pkg` holds:
  - opcode localparams (`ALU_AND` … `ALU_DIV`)
  - FSM state enum (IDLE, RUN, FIX)
  - a helper function for signed SLT compare
- Sub-module `mips_muldiv_core` holds the iteration counter, partial product/remainder registers and shift-add/restore step. It is parametrised by WIDTH; the divide path is guarded by `ALU_DIV_EN`. The top level owns the FSM, handshake, sign handling, flags and hi/lo.

## Test plan
- ADD 0x7FFFFFFF+0x00000001 → result 0x80000000, `overflow`=1, `done` one cycle after accept; SUB 5−5 → result 0, `zero`=1.
- SLT a=0xFFFFFFFF b=1 → result 1; code 0011 → result 0, `illegal`=1.
- MULT a=−3 b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. `busy` high 33 cycles, `done` on the cycle after edge 33. A `start` pulse at edge 10 is ignored.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MFHI → result 0xFFFFFFFE.
- DIV a=−7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=9 b=0 → lo=0xFFFFFFFF, hi=9, `div0`=1. Without `ALU_DIV_EN`: DIV → `illegal`=1, hi/lo unchanged.
- Assert `rst_n`=0 at RUN iteration 12 → `busy`=0, hi=lo=0, no `done`. Following AND 0xF0F0&0xFF00 → result 0xF000 one cycle later.
